tero_eval_sequencer: RTL and testbench

// - Next-generation TERO evaluation controller: evaluates NUM_CH loops in parallel per group, sequencing all NUM_LOOPS/NUM_CH groups.
// - Accumulates per-channel oscillation counts internally over 2**rep_log2 repetitions and emits averaged responses.
// - Output uses a valid/ready handshake; eval time and repetition count are runtime inputs latched at start.
// - Sits between the TERO loop array (drives reset/enable/group select, reads counts) and the response post-processing/readout logic.

---
 rtl/tero_pkg.sv | 35 +++
 rtl/tero_eval_sequencer_if.sv | 19 +
 rtl/tero_group_sel.sv | 54 +++++
 rtl/tero_eval_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_tero_eval_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tero_pkg.sv
// Shared types and helpers for the TERO evaluation sequencer.
// Contents:
//   state_e   - sequencer state encoding (3 bits)
//   grp_bits  - width of a group index (at least 1 bit)
//   acc_bits  - accumulator width sized for the maximum repetition count
//   ch_lsb    - LSB position of channel c in a packed per-channel bus
package tero_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_IDLE   = 3'd1,
    S_INIT   = 3'd2,
    S_EVAL   = 3'd3,
    S_SAMPLE = 3'd4,
    S_OUTPUT = 3'd5,
    S_NEXT   = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  function automatic int unsigned grp_bits(input int unsigned n_groups);
    return (n_groups > 1) ? $clog2(n_groups) : 1;
  endfunction

  // Summing 2**max_rep_log2 counts of cnt_bits each never overflows this width.
  function automatic int unsigned acc_bits(input int unsigned cnt_bits,
                                           input int unsigned max_rep_log2);
    return cnt_bits + max_rep_log2;
  endfunction

  function automatic int unsigned ch_lsb(input int unsigned ch,
                                         input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/tero_eval_sequencer_if.sv
// Response channel of the TERO evaluation sequencer (valid/ready).
// Signals:
//   resp_valid - resp_data/resp_group valid (master drives)
//   resp_ready - consumer accepts on valid && ready (slave drives)
//   resp_data  - NUM_CH averaged counts, channel c at [c*CNT_BITS +: CNT_BITS]
//   resp_group - group index the data belongs to
interface tero_eval_sequencer_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_BITS = 16,
  parameter int unsigned GRP_BITS = 2
);
  logic                       resp_valid;
  logic                       resp_ready;
  logic [NUM_CH*CNT_BITS-1:0] resp_data;
  logic [GRP_BITS-1:0]        resp_group;

  modport master (output resp_valid, resp_data, resp_group, input resp_ready);
  modport slave  (input resp_valid, resp_data, resp_group, output resp_ready);
endinterface

// File: rtl/tero_group_sel.sv
// Group sequencing for the TERO evaluation sequencer.
// Holds the current group and how many groups have been completed.
// Ports:
//   clk, clr  - clock, synchronous clear (reset or abort)
//   load, g0  - start a pass at group g0
//   inc       - advance to the next group, wrapping modulo NUM_GROUPS
//   group     - group currently selected
//   last      - current group is the final one of the pass
module tero_group_sel
  import tero_pkg::*;
#(
  parameter  int unsigned NUM_GROUPS = 4,
  localparam int unsigned GRP_BITS   = grp_bits(NUM_GROUPS)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                load,
  input  logic                inc,
  input  logic [GRP_BITS-1:0] g0,
  output logic [GRP_BITS-1:0] group,
  output logic                last
);

  localparam logic [GRP_BITS-1:0] GMAX = GRP_BITS'(NUM_GROUPS - 1);

  logic [GRP_BITS-1:0] group_q, group_d;
  logic [GRP_BITS-1:0] visited_q, visited_d;

  always_comb begin
    group_d   = group_q;
    visited_d = visited_q;
    if (load) begin
      group_d   = g0;
      visited_d = '0;
    end else if (inc) begin
      group_d   = (group_q == GMAX) ? '0 : group_q + 1'b1;
      visited_d = visited_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      group_q   <= '0;
      visited_q <= '0;
    end else begin
      group_q   <= group_d;
      visited_q <= visited_d;
    end
  end

  assign group = group_q;
  assign last  = (visited_q == GMAX);

endmodule

// File: rtl/tero_eval_sequencer.sv
// TERO evaluation sequencer: evaluates NUM_CH loops per group in parallel,
// repeats each group 2**rep_log2 times, accumulates the counts and emits the
// per-channel average over a valid/ready response channel.
// Optional feature macro: TERO_SEQ_ABORT_EN (adds abort input / aborted output).
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   start            - begin a full evaluation (sampled in IDLE, held to stay in DONE)
//   challenge        - starting group = challenge mod NUM_GROUPS
//   eval_time        - enabled cycles per window minus 1 (latched at start)
//   rep_log2         - log2 repetitions, clamped to MAX_REP_LOG2 (latched at start)
//   reset_puf        - clears the loop oscillators/counters
//   enable_puf       - enables the selected group's loops
//   select_group     - group driven to the loop array
//   puf_count        - per-channel counts from the loop array
//   resp             - response channel (master)
//   abort, aborted   - (TERO_SEQ_ABORT_EN) cancel a busy evaluation / 1-cycle pulse
//   busy, done       - evaluation in progress / evaluation complete
module tero_eval_sequencer
  import tero_pkg::*;
#(
  parameter  int unsigned NUM_LOOPS      = 8,
  parameter  int unsigned NUM_CH         = 2,
  parameter  int unsigned CNT_BITS       = 16,
  parameter  int unsigned EVAL_TIME_BITS = 16,
  parameter  int unsigned MAX_REP_LOG2   = 13,
  parameter  int unsigned CHALLENGE_BITS = 4,
  localparam int unsigned NUM_GROUPS     = NUM_LOOPS / NUM_CH,
  localparam int unsigned GRP_BITS       = grp_bits(NUM_GROUPS),
  localparam int unsigned RL_BITS        = $clog2(MAX_REP_LOG2 + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CHALLENGE_BITS-1:0]  challenge,
  input  logic [EVAL_TIME_BITS-1:0]  eval_time,
  input  logic [RL_BITS-1:0]         rep_log2,
  output logic                       reset_puf,
  output logic                       enable_puf,
  output logic [GRP_BITS-1:0]        select_group,
  input  logic [NUM_CH*CNT_BITS-1:0] puf_count,
  tero_eval_sequencer_if.master      resp,
`ifdef TERO_SEQ_ABORT_EN
  input  logic                       abort,
  output logic                       aborted,
`endif
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned ACC_BITS = acc_bits(CNT_BITS, MAX_REP_LOG2);
  localparam int unsigned REP_BITS = MAX_REP_LOG2 + 1;

  state_e                     state_q, state_d;
  logic [EVAL_TIME_BITS-1:0]  eval_time_q, dly_q;
  logic [RL_BITS-1:0]         rep_log2_q;
  logic [REP_BITS-1:0]        rep_q;
  logic [GRP_BITS-1:0]        resp_group_q, cur_group, g0;
  logic [NUM_CH*CNT_BITS-1:0] data_w;
  logic                       last_group, rep_done, eval_end;
  logic                       grp_inc, start_acc, last_smp, kill;

  assign g0        = GRP_BITS'(challenge % NUM_GROUPS);
  assign rep_done  = (rep_q + 1'b1) == (REP_BITS'(1) << rep_log2_q);
  assign eval_end  = (dly_q == eval_time_q);
  assign start_acc = (state_q == S_IDLE) && start;
  assign last_smp  = (state_q == S_SAMPLE) && rep_done;
  // Entering RESET from a busy state (abort) clears the datapath like reset.
  assign kill      = (state_d == S_RESET);

  always_comb begin
    state_d         = state_q;
    reset_puf       = 1'b0;
    enable_puf      = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    resp.resp_valid = 1'b0;
    grp_inc         = 1'b0;
    unique case (state_q)
      S_RESET: begin
        reset_puf = 1'b1;
        state_d   = S_IDLE;
      end
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: begin
        reset_puf = 1'b1;
        busy      = 1'b1;
        state_d   = S_EVAL;
      end
      S_EVAL: begin
        enable_puf = 1'b1;
        busy       = 1'b1;
        if (eval_end) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy    = 1'b1;
        state_d = rep_done ? S_OUTPUT : S_INIT;
      end
      S_OUTPUT: begin
        busy            = 1'b1;
        resp.resp_valid = 1'b1;
        if (resp.resp_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        busy = 1'b1;
        if (last_group) state_d = S_DONE;
        else begin
          grp_inc = 1'b1;
          state_d = S_INIT;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_RESET;
    endcase
`ifdef TERO_SEQ_ABORT_EN
    if (abort && busy) state_d = S_RESET;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

`ifdef TERO_SEQ_ABORT_EN
  logic aborted_q;
  always_ff @(posedge clk) begin
    if (reset) aborted_q <= 1'b0;
    else       aborted_q <= abort && busy;
  end
  assign aborted = aborted_q;
`endif

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      eval_time_q  <= '0;
      rep_log2_q   <= '0;
      dly_q        <= '0;
      rep_q        <= '0;
      resp_group_q <= '0;
    end else begin
      if (start_acc) begin
        eval_time_q <= eval_time;
        rep_log2_q  <= (rep_log2 > RL_BITS'(MAX_REP_LOG2)) ? RL_BITS'(MAX_REP_LOG2) : rep_log2;
        rep_q       <= '0;
      end
      unique case (state_q)
        S_INIT:   dly_q <= '0;
        S_EVAL:   dly_q <= dly_q + 1'b1;
        S_SAMPLE: begin
          rep_q <= rep_q + 1'b1;
          if (rep_done) resp_group_q <= cur_group;
        end
        S_NEXT:   rep_q <= '0;
        default:  ;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_BITS-1:0] acc_q, sum;
    logic [CNT_BITS-1:0] avg_q;

    assign sum = acc_q + ACC_BITS'(puf_count[ch_lsb(c, CNT_BITS) +: CNT_BITS]);

    always_ff @(posedge clk) begin
      if (reset || kill || start_acc || state_q == S_NEXT) acc_q <= '0;
      else if (state_q == S_SAMPLE)                        acc_q <= sum;
      // Average never exceeds one count, so truncation to CNT_BITS is lossless.
      if (reset || kill)  avg_q <= '0;
      else if (last_smp)  avg_q <= CNT_BITS'(sum >> rep_log2_q);
    end

    assign data_w[ch_lsb(c, CNT_BITS) +: CNT_BITS] = avg_q;
  end

  tero_group_sel #(.NUM_GROUPS(NUM_GROUPS)) u_group_sel (
    .clk   (clk),
    .clr   (reset || kill),
    .load  (start_acc),
    .inc   (grp_inc),
    .g0    (g0),
    .group (cur_group),
    .last  (last_group)
  );

  assign select_group    = cur_group;
  assign resp.resp_data  = data_w;
  assign resp.resp_group = resp_group_q;

endmodule

// File: tb/tb_tero_eval_sequencer.sv
// Testbench for tero_eval_sequencer: a loop-array model feeds counts, expected
// averages are queued at start and compared by a monitor on each handshake.
// Optional macro: TERO_SEQ_ABORT_EN enables the abort scenarios.
module tb_tero_eval_sequencer;
  import tero_pkg::*;

  localparam int unsigned NUM_LOOPS = 8;
  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned CNT_BITS  = 16;
  localparam int unsigned ETB       = 16;
  localparam int unsigned MAXR      = 13;
  localparam int unsigned CB        = 4;
  localparam int unsigned NG        = NUM_LOOPS / NUM_CH;
  localparam int unsigned GB        = grp_bits(NG);
  localparam int unsigned RLB       = $clog2(MAXR + 1);
  localparam int unsigned DW        = NUM_CH * CNT_BITS;

  typedef struct {
    logic [GB-1:0] g;
    logic [DW-1:0] d;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [CB-1:0]  challenge;
  logic [ETB-1:0] eval_time;
  logic [RLB-1:0] rep_log2;
  logic           reset_puf, enable_puf, busy, done;
  logic [GB-1:0]  select_group;
  logic [DW-1:0]  puf_count;
`ifdef TERO_SEQ_ABORT_EN
  logic           abort, aborted;
`endif

  tero_eval_sequencer_if #(.NUM_CH(NUM_CH), .CNT_BITS(CNT_BITS), .GRP_BITS(GB)) rif ();

  tero_eval_sequencer #(
    .NUM_LOOPS(NUM_LOOPS), .NUM_CH(NUM_CH), .CNT_BITS(CNT_BITS),
    .EVAL_TIME_BITS(ETB), .MAX_REP_LOG2(MAXR), .CHALLENGE_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .eval_time(eval_time), .rep_log2(rep_log2), .reset_puf(reset_puf),
    .enable_puf(enable_puf), .select_group(select_group), .puf_count(puf_count),
    .resp(rif),
`ifdef TERO_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          nchk = 0, nfail = 0, nhs = 0;
  int          ready_mode = 0;
  int unsigned exp_len = 1;
  bit          len_chk = 1'b0;
  exp_t        expq[$];

  // Loop-array model: each loop counts 'rate' per enabled cycle, starting from
  // a per-window offset loaded when the oscillators are cleared.
  int unsigned          rate [NUM_LOOPS];
  int unsigned          extra [64][NUM_CH];
  int unsigned          win = 0;
  logic [CNT_BITS-1:0]  cnt [NUM_CH];

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset_puf === 1'b1)
        cnt[c] <= CNT_BITS'(extra[win % 64][c]);
      else if (enable_puf === 1'b1)
        cnt[c] <= cnt[c] + CNT_BITS'(rate[int'(select_group) * NUM_CH + c]);
    end
    if (reset_puf === 1'b1)                   win <= win + 1;
    else if (busy !== 1'b1)                   win <= 0;
  end

  always_comb begin
    puf_count = '0;
    for (int c = 0; c < NUM_CH; c++) puf_count[c*CNT_BITS +: CNT_BITS] = cnt[c];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected response per group: mean of the 2**r window counts, floored.
  task automatic push_expected(input int unsigned ch, input int unsigned et, input int unsigned rl);
    int unsigned     r    = (rl > MAXR) ? MAXR : rl;
    longint unsigned reps = longint'(1) << r;
    for (int unsigned gi = 0; gi < NG; gi++) begin
      exp_t        e;
      int unsigned g;
      g   = (ch + gi) % NG;
      e.g = GB'(g);
      e.d = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        longint unsigned sum;
        sum = 0;
        for (longint unsigned k = 0; k < reps; k++)
          sum += (longint'(rate[g*NUM_CH + c]) * (et + 1) + extra[(gi*reps + k) % 64][c]) & 64'hFFFF;
        e.d[c*CNT_BITS +: CNT_BITS] = CNT_BITS'(sum >> r);
      end
      expq.push_back(e);
    end
  endtask

  task automatic run_start(input int unsigned ch, input int unsigned et,
                           input int unsigned rl, input bit hold);
    challenge = CB'(ch);
    eval_time = ETB'(et);
    rep_log2  = RLB'(rl);
    exp_len   = et + 1;
    len_chk   = 1'b1;
    push_expected(ch, et, rl);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, {63'd0, done}, 64'd1);
    check({name, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    check({name, "_queue_empty"}, 64'(expq.size()), 64'd0);
    start = 1'b0;
    tick();
    tick();
    check({name, "_back_idle"}, {63'd0, done}, 64'd0);
  endtask

  task automatic set_stim(input int unsigned max_rate, input int unsigned max_extra);
    for (int i = 0; i < NUM_LOOPS; i++) rate[i] = $urandom_range(0, max_rate);
    for (int w = 0; w < 64; w++)
      for (int c = 0; c < NUM_CH; c++) extra[w][c] = $urandom_range(0, max_extra);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_reset_puf"}, {63'd0, reset_puf}, 64'd0);
    check({name, "_enable_puf"}, {63'd0, enable_puf}, 64'd0);
    check({name, "_valid"}, {63'd0, rif.resp_valid}, 64'd0);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_done"}, {63'd0, done}, 64'd0);
    check({name, "_group"}, 64'(select_group), 64'd0);
    check({name, "_data"}, 64'(rif.resp_data), 64'd0);
  endtask

  // Response ready driver.
  initial begin
    rif.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rif.resp_ready = 1'b1;
        1:       rif.resp_ready = ($urandom_range(0, 1) == 1);
        default: rif.resp_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: compare on each accepted response.
  initial begin
    forever begin
      @(negedge clk);
      if (rif.resp_valid === 1'b1 && rif.resp_ready === 1'b1) begin
        nhs++;
        if (expq.size() == 0) begin
          check("unexpected_response", 64'(rif.resp_group), 64'hDEAD);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("resp_group", 64'(rif.resp_group), 64'(e.g));
          check("resp_data", 64'(rif.resp_data), 64'(e.d));
        end
      end
    end
  end

  // Window timing: enable lasts eval_time+1 cycles, preceded by a reset_puf cycle.
  initial begin
    int run;
    bit en_p, rp_p;
    run = 0; en_p = 1'b0; rp_p = 1'b0;
    forever begin
      @(negedge clk);
      if (enable_puf === 1'b1) begin
        if (!en_p && len_chk) check("reset_puf_before_enable", {63'd0, rp_p}, 64'd1);
        run++;
      end else begin
        if (en_p && len_chk) check("enable_len", 64'(run), 64'(exp_len));
        run = 0;
      end
      en_p = (enable_puf === 1'b1);
      rp_p = (reset_puf === 1'b1);
    end
  end

  initial begin
    int          hs0, n, bad;
    logic [DW-1:0] cap_d;
    logic [GB-1:0] cap_g;
    reset = 1'b1; start = 1'b0; challenge = '0; eval_time = '0; rep_log2 = '0;
`ifdef TERO_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < NUM_LOOPS; i++) rate[i] = 25;
    for (int w = 0; w < 64; w++)
      for (int c = 0; c < NUM_CH; c++) extra[w][c] = 0;

    // Reset state
    tick();
    tick();
    check("rst_reset_puf", {63'd0, reset_puf}, 64'd1);
    check("rst_enable_puf", {63'd0, enable_puf}, 64'd0);
    check("rst_valid", {63'd0, rif.resp_valid}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    tick();
    check_idle_outputs("idle_after_reset");

    // Constant count 100, start held high through the run
    hs0 = nhs;
    run_start(5, 3, 2, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    check("t1_handshakes", 64'(nhs - hs0), 64'(NG));
    repeat (3) tick();
    check("t1_done_held", {63'd0, done}, 64'd1);
    wait_done(10, "t1");

    // Per-rep counts 10,20,30,40 on ch0 average to 25
    for (int i = 0; i < NUM_LOOPS; i++) rate[i] = 0;
    for (int w = 0; w < 64; w++) begin
      extra[w][0] = 10 * (w % 4 + 1);
      extra[w][1] = $urandom_range(0, 1000);
    end
    run_start(0, 3, 2, 1'b0);
    wait_done(500, "t2");

    // Stall in OUTPUT for 50 cycles
    set_stim(300, 40);
    ready_mode = 2;
    hs0 = nhs;
    run_start($urandom_range(0, 15), 1, 1, 1'b0);
    n = 0;
    while (rif.resp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("stall_valid_seen", {63'd0, rif.resp_valid}, 64'd1);
    cap_d = rif.resp_data;
    cap_g = rif.resp_group;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (rif.resp_valid !== 1'b1 || rif.resp_data !== cap_d ||
          rif.resp_group !== cap_g || enable_puf !== 1'b0) bad++;
    end
    check("stall_stable", 64'(bad), 64'd0);
    ready_mode = 0;
    wait_done(300, "stall");
    check("stall_handshakes", 64'(nhs - hs0), 64'(NG));

    // Randomized runs with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      set_stim(300, 40);
      run_start($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 3), 1'b0);
      wait_done(3000, "rand");
    end
    ready_mode = 0;

    // Clamp: rep_log2=15 behaves as 13 (8192 reps), max count, no overflow
    for (int i = 0; i < NUM_LOOPS; i++) rate[i] = 32'hFFFF;
    for (int w = 0; w < 64; w++)
      for (int c = 0; c < NUM_CH; c++) extra[w][c] = 0;
    hs0 = nhs;
    run_start(2, 0, 15, 1'b0);
    n = 0;
    while (nhs == hs0 && n < 30000) begin @(negedge clk); n++; end
    check("clamp_response_seen", 64'(nhs - hs0), 64'd1);
    check("clamp_reps", 64'(win), 64'd8192);
    len_chk = 1'b0;
    reset = 1'b1;
    tick();
    expq.delete();
    reset = 1'b0;
    tick();
    check_idle_outputs("clamp_reset");

    // Reset mid-EVAL
    set_stim(300, 40);
    run_start($urandom_range(0, 15), 5, 1, 1'b0);
    n = 0;
    while (enable_puf !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("mid_eval_reached", {63'd0, enable_puf}, 64'd1);
    len_chk = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_reset_puf", {63'd0, reset_puf}, 64'd1);
    check("mid_rst_enable", {63'd0, enable_puf}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    expq.delete();
    reset = 1'b0;
    tick();
    check_idle_outputs("mid_rst_idle");
    set_stim(300, 40);
    run_start($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 3), 1'b0);
    wait_done(3000, "after_reset");

`ifdef TERO_SEQ_ABORT_EN
    // Abort ignored when idle
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", {63'd0, busy}, 64'd0);
    check("idle_abort_pulse", {63'd0, aborted}, 64'd0);
    check("idle_abort_reset_puf", {63'd0, reset_puf}, 64'd0);

    // Abort in the second group's SAMPLE
    set_stim(300, 40);
    hs0 = nhs;
    run_start(2, 2, 1, 1'b0);
    n = 0;
    while (nhs == hs0 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (enable_puf !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (enable_puf !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("abort_first_resp", 64'(nhs - hs0), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_pulse", {63'd0, aborted}, 64'd1);
    check("abort_reset_puf", {63'd0, reset_puf}, 64'd1);
    check("abort_valid", {63'd0, rif.resp_valid}, 64'd0);
    expq.delete();
    tick();
    check("abort_pulse_end", {63'd0, aborted}, 64'd0);
    check_idle_outputs("abort_idle");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    check("abort_no_done", 64'(bad), 64'd0);
    set_stim(300, 40);
    run_start($urandom_range(0, 15), 1, 1, 1'b0);
    wait_done(1000, "after_abort");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
